// File: rtl/ifetch_queue_pkg.sv
// Shared definitions for the instruction-fetch queue: default widths,
// fetch FSM state encodings and a small sizing helper.
package ifetch_queue_pkg;

    localparam int IFQ_ADDR_W = 6;
    localparam int IFQ_DATA_W = 32;
    localparam int IFQ_DEPTH  = 4;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_STALL = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_t;

    // Occupancy counters need one extra bit so that "full" (== depth) fits.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ifetch_queue_sync_fifo.sv
// Generic synchronous FIFO with flush and an occupancy count. Storage is
// cleared by reset only; flush just rewinds the pointers. The head entry is
// presented combinationally on pop_data.
module sync_fifo #(
    parameter int WIDTH = 38,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign pop_data = mem[rd_ptr];

    // Pointer, count and storage update; flush empties without touching storage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch stage: owns the fetch pointer, issues one request at a
// time to instruction memory, and buffers returned {instr, addr} pairs for
// decode. A redirect flushes the buffer; a request already in flight at the
// time of a redirect is allowed to complete and its word is thrown away.
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int ADDR_W = IFQ_ADDR_W,
    parameter int DATA_W = IFQ_DATA_W,
    parameter int DEPTH  = IFQ_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_addr
);

    localparam int CNT_W   = count_width(DEPTH);
    localparam int ENTRY_W = DATA_W + ADDR_W;

    fetch_state_t       state;
    fetch_state_t       state_next;
    logic [ADDR_W-1:0]  fetch_ptr;
    logic [ADDR_W-1:0]  fetch_ptr_next;
    logic               req;
    logic               req_next;
    logic [ADDR_W-1:0]  req_addr;
    logic [ADDR_W-1:0]  req_addr_next;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W-1:0]   count_next;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] head;
    logic               ack_hit;
    logic               still_pending;
    logic               discard;
    logic               push;
    logic               pop;

    // A redirect hides the head so decode cannot consume a word being flushed.
    assign instr_valid   = !fifo_empty && !redirect_valid;
    assign pop           = instr_valid && instr_ready;
    assign ack_hit       = req && mem_ack;
    assign still_pending = req && !mem_ack;
    assign discard       = redirect_valid || (state == S_DRAIN);
    assign push          = ack_hit && !discard;

    assign mem_req                  = req;
    assign mem_addr                 = req_addr;
    assign {instr_data, instr_addr} = head;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data ({mem_rdata, req_addr}),
        .pop       (pop),
        .pop_data  (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Predict next-cycle occupancy so a new request is only issued into a free slot.
    always_comb begin
        count_next = fifo_count;
        if (redirect_valid) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = fifo_count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = fifo_count - CNT_W'(1);
        end
    end

    // Fetch FSM next state, fetch pointer and the next request to present.
    always_comb begin
        state_next     = state;
        fetch_ptr_next = fetch_ptr;
        req_next       = 1'b0;
        req_addr_next  = req_addr;

        if (redirect_valid) begin
            fetch_ptr_next = redirect_addr;
        end else if (ack_hit && (state != S_DRAIN)) begin
            fetch_ptr_next = fetch_ptr + ADDR_W'(1);
        end

        case (state)
            S_DRAIN: begin
                if (ack_hit) begin
                    state_next = S_FETCH;
                end
            end
            default: begin
                if (redirect_valid && still_pending) begin
                    state_next = S_DRAIN;
                end else if (!still_pending && (count_next >= CNT_W'(DEPTH))) begin
                    state_next = S_STALL;
                end else begin
                    state_next = S_FETCH;
                end
            end
        endcase

        if (still_pending) begin
            req_next = 1'b1;
        end else if (state_next == S_FETCH) begin
            req_next      = 1'b1;
            req_addr_next = fetch_ptr_next;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Fetch pointer and the held request; a reset abandons any request in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_ptr <= '0;
            req       <= 1'b0;
            req_addr  <= '0;
        end else begin
            fetch_ptr <= fetch_ptr_next;
            req       <= req_next;
            req_addr  <= req_addr_next;
        end
    end

endmodule
